// File: rtl/pwm_regs_mc.sv
// Register file for a bank of PWM channels: double-buffered period/compare,
// unbuffered control/prescale, command strobes, sticky overflow status and irq.
module pwm_regs_mc #(
  parameter int NUM_CH = 4,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read,
  input  logic                 write,
  input  logic [7:0]           addr,
  input  logic [7:0]           data_write,
  output logic [7:0]           data_read,
  input  logic [NUM_CH*CW-1:0] counter_val,
  input  logic [NUM_CH-1:0]    ovf,
  output logic [NUM_CH*CW-1:0] period,
  output logic [NUM_CH*CW-1:0] compare1,
  output logic [NUM_CH*CW-1:0] compare2,
  output logic [NUM_CH-1:0]    en,
  output logic [NUM_CH-1:0]    upnotdown,
  output logic [NUM_CH-1:0]    pwm_en,
  output logic [NUM_CH-1:0]    count_reset,
  output logic [NUM_CH*8-1:0]  prescale,
  output logic [NUM_CH*2-1:0]  functions,
  output logic                 irq
);

  localparam int NB = CW / 8;

  localparam logic [2:0] R_PERIOD   = 3'd0;
  localparam logic [2:0] R_COMPARE1 = 3'd1;
  localparam logic [2:0] R_COMPARE2 = 3'd2;
  localparam logic [2:0] R_CTRL     = 3'd3;
  localparam logic [2:0] R_PRESCALE = 3'd4;
  localparam logic [2:0] R_COUNTER  = 3'd5;
  localparam logic [2:0] R_CMD      = 3'd6;
  localparam logic [2:0] R_STATUS   = 3'd7;

  logic [2:0] ch, ridx;
  logic [1:0] bsel;
  logic [4:0] bsh;
  logic       byte_ok;

  assign ch      = addr[7:5];
  assign ridx    = addr[4:2];
  assign bsel    = addr[1:0];
  assign bsh     = {bsel, 3'b000};
  assign byte_ok = ({1'b0, bsel} < 3'(NB));

  logic [CW-1:0] rd_period [NUM_CH];
  logic [CW-1:0] rd_cmp1   [NUM_CH];
  logic [CW-1:0] rd_cmp2   [NUM_CH];
  logic [CW-1:0] rd_cnt    [NUM_CH];
  logic [7:0]    rd_ctrl   [NUM_CH];
  logic [7:0]    rd_pre    [NUM_CH];
  logic [7:0]    rd_stat   [NUM_CH];
  logic [NUM_CH-1:0] irq_src;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [CW-1:0] p_sh, c1_sh, c2_sh, p_act, c1_act, c2_act;
    logic [CW-1:0] bmask, bdata;
    logic [7:0]    pre_r;
    logic [1:0]    fn_r;
    logic          en_r, ud_r, pwm_r, ie_r, pend_r, stk_r, cr_r;
    logic          sel, byte0, wr_sh, cmd_wr, upd;

    assign sel    = write && (ch == 3'(n)) && byte_ok;
    assign byte0  = sel && (bsel == 2'd0);
    assign wr_sh  = sel && (ridx <= R_COMPARE2);
    assign cmd_wr = byte0 && (ridx == R_CMD);
    // Copy uses the pre-edge shadow, so a same-cycle shadow write lands after it.
    assign upd    = pend_r && (ovf[n] || !en_r || (cmd_wr && data_write[1]));
    assign bmask  = ~(CW'(8'hFF) << bsh);
    assign bdata  = CW'(data_write) << bsh;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_sh   <= '0;
        c1_sh  <= '0;
        c2_sh  <= '0;
        p_act  <= '0;
        c1_act <= '0;
        c2_act <= '0;
        pre_r  <= '0;
        fn_r   <= '0;
        en_r   <= 1'b0;
        ud_r   <= 1'b1;
        pwm_r  <= 1'b0;
        ie_r   <= 1'b0;
        pend_r <= 1'b0;
        stk_r  <= 1'b0;
        cr_r   <= 1'b0;
      end else begin
        if (upd) begin
          p_act  <= p_sh;
          c1_act <= c1_sh;
          c2_act <= c2_sh;
        end
        if (wr_sh && ridx == R_PERIOD)   p_sh  <= (p_sh & bmask) | bdata;
        if (wr_sh && ridx == R_COMPARE1) c1_sh <= (c1_sh & bmask) | bdata;
        if (wr_sh && ridx == R_COMPARE2) c2_sh <= (c2_sh & bmask) | bdata;
        if (wr_sh)    pend_r <= 1'b1;
        else if (upd) pend_r <= 1'b0;
        if (byte0 && ridx == R_CTRL)
          {ie_r, fn_r, pwm_r, ud_r, en_r} <= data_write[5:0];
        if (byte0 && ridx == R_PRESCALE) pre_r <= data_write;
        cr_r <= cmd_wr && data_write[0];
        if (ovf[n])
          stk_r <= 1'b1;
        else if (byte0 && ridx == R_STATUS && data_write[0])
          stk_r <= 1'b0;
      end
    end

    assign period[n*CW +: CW]   = p_act;
    assign compare1[n*CW +: CW] = c1_act;
    assign compare2[n*CW +: CW] = c2_act;
    assign prescale[n*8 +: 8]   = pre_r;
    assign functions[n*2 +: 2]  = fn_r;
    assign en[n]          = en_r;
    assign upnotdown[n]   = ud_r;
    assign pwm_en[n]      = pwm_r;
    assign count_reset[n] = cr_r;
    assign irq_src[n]     = stk_r & ie_r;

    assign rd_period[n] = p_sh;
    assign rd_cmp1[n]   = c1_sh;
    assign rd_cmp2[n]   = c2_sh;
    assign rd_cnt[n]    = counter_val[n*CW +: CW];
    assign rd_ctrl[n]   = {2'b00, ie_r, fn_r, pwm_r, ud_r, en_r};
    assign rd_pre[n]    = pre_r;
    assign rd_stat[n]   = {6'b0, pend_r, stk_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |irq_src;
  end

  function automatic logic [7:0] pick(input logic [CW-1:0] v, input logic [4:0] sh);
    logic [CW-1:0] t;
    t = v >> sh;
    return t[7:0];
  endfunction

  logic          ch_ok;
  logic [CW-1:0] s_period, s_cmp1, s_cmp2, s_cnt;
  logic [7:0]    s_ctrl, s_pre, s_stat;

  always_comb begin
    ch_ok    = 1'b0;
    s_period = '0;
    s_cmp1   = '0;
    s_cmp2   = '0;
    s_cnt    = '0;
    s_ctrl   = '0;
    s_pre    = '0;
    s_stat   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch == 3'(n)) begin
        ch_ok    = 1'b1;
        s_period = rd_period[n];
        s_cmp1   = rd_cmp1[n];
        s_cmp2   = rd_cmp2[n];
        s_cnt    = rd_cnt[n];
        s_ctrl   = rd_ctrl[n];
        s_pre    = rd_pre[n];
        s_stat   = rd_stat[n];
      end
    end
    data_read = 8'h00;
    if (read) begin
      if (!ch_ok || ridx == R_CMD) begin
        data_read = 8'hFF;
      end else if (byte_ok) begin
        case (ridx)
          R_PERIOD:   data_read = pick(s_period, bsh);
          R_COMPARE1: data_read = pick(s_cmp1, bsh);
          R_COMPARE2: data_read = pick(s_cmp2, bsh);
          R_COUNTER:  data_read = pick(s_cnt, bsh);
          R_CTRL:     data_read = (bsel == 2'd0) ? s_ctrl : 8'h00;
          R_PRESCALE: data_read = (bsel == 2'd0) ? s_pre : 8'h00;
          R_STATUS:   data_read = (bsel == 2'd0) ? s_stat : 8'h00;
          default:    data_read = 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Directed bench for pwm_regs_mc (4 channels, 16-bit), hand-computed expectations.
module tb_pwm_regs_mc;
  localparam int NUM_CH = 4;
  localparam int CW     = 16;

  localparam logic [2:0] R_PERIOD   = 3'd0;
  localparam logic [2:0] R_COMPARE1 = 3'd1;
  localparam logic [2:0] R_CTRL     = 3'd3;
  localparam logic [2:0] R_PRESCALE = 3'd4;
  localparam logic [2:0] R_COUNTER  = 3'd5;
  localparam logic [2:0] R_CMD      = 3'd6;
  localparam logic [2:0] R_STATUS   = 3'd7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 read = 1'b0;
  logic                 write = 1'b0;
  logic [7:0]           addr = '0;
  logic [7:0]           data_write = '0;
  logic [7:0]           data_read;
  logic [NUM_CH*CW-1:0] counter_val = '0;
  logic [NUM_CH-1:0]    ovf = '0;
  logic [NUM_CH*CW-1:0] period, compare1, compare2;
  logic [NUM_CH-1:0]    en, upnotdown, pwm_en, count_reset;
  logic [NUM_CH*8-1:0]  prescale;
  logic [NUM_CH*2-1:0]  functions;
  logic                 irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] rv;

  pwm_regs_mc #(.NUM_CH(NUM_CH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .ovf(ovf), .period(period), .compare1(compare1), .compare2(compare2),
    .en(en), .upnotdown(upnotdown), .pwm_en(pwm_en), .count_reset(count_reset),
    .prescale(prescale), .functions(functions), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] c, input logic [2:0] r, input logic [1:0] b,
                    input logic [7:0] d);
    @(negedge clk);
    addr = {c, r, b};
    data_write = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] c, input logic [2:0] r, input logic [1:0] b,
                    output logic [7:0] d);
    @(negedge clk);
    addr = {c, r, b};
    read = 1'b1;
    #1 d = data_read;
    read = 1'b0;
  endtask

  task automatic pulse_ovf(input logic [NUM_CH-1:0] m);
    @(negedge clk);
    ovf = m;
    @(negedge clk);
    ovf = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_period", period, 64'h0);
    check("rst_en", en, 4'h0);
    check("rst_ud", upnotdown, 4'hF);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;

    // ch0 double-buffered period applied on overflow
    wr(3'd0, R_CTRL, 2'd0, 8'h03);
    wr(3'd0, R_PERIOD, 2'd0, 8'h34);
    wr(3'd0, R_PERIOD, 2'd1, 8'h12);
    check("p0_held", period[15:0], 16'h0000);
    rd(3'd0, R_STATUS, 2'd0, rv);
    check("p0_pending", rv, 8'h02);
    rd(3'd0, R_PERIOD, 2'd1, rv);
    check("p0_shadow_rd", rv, 8'h12);
    pulse_ovf(4'b0001);
    check("p0_applied", period[15:0], 16'h1234);
    rd(3'd0, R_STATUS, 2'd0, rv);
    check("p0_status", rv, 8'h01);

    // ch1 disabled: copy on the edge after the shadow write
    wr(3'd1, R_COMPARE1, 2'd0, 8'h80);
    check("c1_edge1", compare1[31:16], 16'h0000);
    @(negedge clk);
    check("c1_edge2", compare1[31:16], 16'h0080);

    // count_reset pulse
    wr(3'd2, R_CMD, 2'd0, 8'h01);
    check("cr_high", count_reset, 4'b0100);
    @(negedge clk);
    check("cr_low", count_reset, 4'b0000);

    // sticky overflow and irq latency
    wr(3'd3, R_CTRL, 2'd0, 8'h22);
    pulse_ovf(4'b1000);
    check("irq_lat0", irq, 1'b0);
    @(negedge clk);
    check("irq_lat1", irq, 1'b1);
    @(negedge clk);
    addr = {3'd3, R_STATUS, 2'd0};
    data_write = 8'h01;
    write = 1'b1;
    ovf = 4'b1000;
    @(negedge clk);
    write = 1'b0;
    ovf = '0;
    rd(3'd3, R_STATUS, 2'd0, rv);
    check("stk_set_wins", rv, 8'h01);
    wr(3'd3, R_STATUS, 2'd0, 8'h01);
    rd(3'd3, R_STATUS, 2'd0, rv);
    check("stk_cleared", rv, 8'h00);
    @(negedge clk);
    check("irq_clear", irq, 1'b0);

    // decode corners
    rd(3'd5, R_PERIOD, 2'd0, rv);
    check("rd_bad_ch", rv, 8'hFF);
    rd(3'd0, R_CMD, 2'd0, rv);
    check("rd_cmd", rv, 8'hFF);
    rd(3'd0, R_PERIOD, 2'd2, rv);
    check("rd_bad_byte", rv, 8'h00);
    rd(3'd0, R_CTRL, 2'd0, rv);
    check("rd_ctrl", rv, 8'h03);
    counter_val[47:32] = 16'hBEEF;
    rd(3'd2, R_COUNTER, 2'd1, rv);
    check("rd_counter", rv, 8'hBE);
    @(negedge clk);
    addr = {3'd0, R_CTRL, 2'd0};
    #1 check("rd_idle", data_read, 8'h00);
    wr(3'd5, R_CTRL, 2'd0, 8'hFF);
    wr(3'd5, R_PRESCALE, 2'd0, 8'hFF);
    check("badch_en", en, 4'b0001);
    check("badch_pwm", pwm_en, 4'b0000);
    check("badch_pre", prescale, 32'h0);
    wr(3'd0, R_PERIOD, 2'd2, 8'hAA);
    rd(3'd0, R_STATUS, 2'd0, rv);
    check("badbyte_nopend", rv, 8'h01);
    wr(3'd1, R_PRESCALE, 2'd0, 8'h5A);
    check("prescale1", prescale[15:8], 8'h5A);

    // shadow write colliding with the copy edge
    wr(3'd0, R_PERIOD, 2'd0, 8'h78);
    @(negedge clk);
    addr = {3'd0, R_PERIOD, 2'd1};
    data_write = 8'h56;
    write = 1'b1;
    ovf = 4'b0001;
    @(negedge clk);
    write = 1'b0;
    ovf = '0;
    check("coll_old", period[15:0], 16'h1278);
    rd(3'd0, R_STATUS, 2'd0, rv);
    check("coll_pend", rv, 8'h03);
    pulse_ovf(4'b0001);
    check("coll_new", period[15:0], 16'h5678);

    // forced update by command
    wr(3'd0, R_PERIOD, 2'd0, 8'h00);
    check("force_held", period[15:0], 16'h5678);
    wr(3'd0, R_CMD, 2'd0, 8'h02);
    check("force_apply", period[15:0], 16'h5600);

    // reset mid-operation kills pending update and live count_reset pulse
    wr(3'd0, R_PERIOD, 2'd1, 8'h99);
    @(negedge clk);
    addr = {3'd1, R_CMD, 2'd0};
    data_write = 8'h01;
    write = 1'b1;
    @(posedge clk);
    #2 write = 1'b0;
    check("pre_rst_cr", count_reset, 4'b0010);
    rst = 1'b1;
    #1;
    check("mid_rst_cr", count_reset, 4'b0000);
    check("mid_rst_period", period, 64'h0);
    check("mid_rst_ud", upnotdown, 4'hF);
    check("mid_rst_pre", prescale, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd0, R_STATUS, 2'd0, rv);
    check("post_rst_status", rv, 8'h00);
    rd(3'd0, R_PERIOD, 2'd1, rv);
    check("post_rst_shadow", rv, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
